// File: rtl/player_mover.sv
// Maze player position controller: synchronizes direction keys, requests a wall check
// for one cell step, then commits or rejects the move; supports hold-to-repeat and a sticky win flag.
module player_mover #(
    parameter int CELL_W        = 32,
    parameter int CELL_H        = 30,
    parameter int START_X       = 0,
    parameter int START_Y       = 0,
    parameter int GOAL_X        = 608,
    parameter int GOAL_Y        = 450,
    parameter int REPEAT_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_left,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_right,
    input  logic       wallblks,
    output logic       left,
    output logic       up,
    output logic       down,
    output logic       right,
    output logic [9:0] xFlr,
    output logic [9:0] xCeil,
    output logic [9:0] yFlr,
    output logic [9:0] yCeil,
    output logic       moved,
    output logic       blocked,
    output logic       won
);

    localparam int CNT_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [9:0] CW  = 10'(CELL_W);
    localparam logic [9:0] CH  = 10'(CELL_H);
    localparam logic [9:0] SX  = 10'(START_X);
    localparam logic [9:0] SY  = 10'(START_Y);
    localparam logic [9:0] GX  = 10'(GOAL_X);
    localparam logic [9:0] GY  = 10'(GOAL_Y);

    typedef enum logic [2:0] {IDLE, REQ, CHECK, HOLD, DONE} state_t;

    // Direction vectors are ordered {right, down, up, left}.
    state_t           state_q, state_d;
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       dir_q, dir_d;
    logic [3:0]       lat_q, lat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic             moved_q, moved_d, blocked_q, blocked_d, won_q, won_d;
    logic [3:0]       sk;
    logic [9:0]       x_nx, y_nx;
    logic             edge_hit;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    assign sk    = sync2_q;
    assign xCeil = x_q + CW;
    assign yCeil = y_q + CH;

    always_comb begin
        x_nx = x_q;
        y_nx = y_q;
        case (dir_q)
            4'b0001: x_nx = x_q - CW;
            4'b0010: y_nx = y_q - CH;
            4'b0100: y_nx = y_q + CH;
            4'b1000: x_nx = x_q + CW;
            default: ;
        endcase
    end

    assign edge_hit = (dir_q[0] && (x_q == 10'd0))   ||
                      (dir_q[3] && (xCeil == 10'd640)) ||
                      (dir_q[1] && (y_q == 10'd0))   ||
                      (dir_q[2] && (yCeil == 10'd480));

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        lat_d     = lat_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        y_d       = y_q;
        moved_d   = 1'b0;
        blocked_d = 1'b0;
        won_d     = won_q;
        case (state_q)
            IDLE: begin
                dir_d = 4'd0;
                if (is_onehot(sk)) begin
                    dir_d   = sk;
                    lat_d   = sk;
                    state_d = REQ;
                end
            end
            REQ: state_d = CHECK;
            CHECK: begin
                if (wallblks || edge_hit) begin
                    blocked_d = 1'b1;
                end else begin
                    moved_d = 1'b1;
                    x_d     = x_nx;
                    y_d     = y_nx;
                end
                dir_d = 4'd0;
                if ((x_d == GX) && (y_d == GY)) begin
                    won_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                dir_d = 4'd0;
                if (sk == 4'd0) begin
                    state_d = IDLE;
                end else if (sk == lat_q) begin
                    // Auto-repeat fires after the key has been held steady long enough.
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        dir_d   = lat_q;
                        state_d = REQ;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: dir_d = 4'd0;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sync1_q   <= 4'd0;
            sync2_q   <= 4'd0;
            dir_q     <= 4'd0;
            lat_q     <= 4'd0;
            cnt_q     <= '0;
            x_q       <= SX;
            y_q       <= SY;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
            won_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= {key_right, key_down, key_up, key_left};
            sync2_q   <= sync1_q;
            dir_q     <= dir_d;
            lat_q     <= lat_d;
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
            won_q     <= won_d;
        end
    end

    assign left    = dir_q[0];
    assign up      = dir_q[1];
    assign down    = dir_q[2];
    assign right   = dir_q[3];
    assign xFlr    = x_q;
    assign yFlr    = y_q;
    assign moved   = moved_q;
    assign blocked = blocked_q;
    assign won     = won_q;

endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover: one instance starting at (0,0), one starting next to the goal.
module tb_player_mover;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] keys = 4'd0;   // {right, down, up, left}
    logic [3:0] gkeys = 4'd0;
    logic       wall_en = 1'b0;
    logic       wallblks;
    logic       left, up, down, right, moved, blocked, won;
    logic [9:0] xFlr, xCeil, yFlr, yCeil;
    logic       g_left, g_up, g_down, g_right, g_moved, g_blocked, g_won;
    logic [9:0] g_xFlr, g_xCeil, g_yFlr, g_yCeil;
    int         n_checks = 0;
    int         n_errors = 0;
    int         acc;

    always #5 clk = ~clk;

    // Wall checker model: reports a wall for whatever direction is requested while enabled.
    assign wallblks = wall_en & (left | up | down | right);

    player_mover #(.REPEAT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .key_left(keys[0]), .key_up(keys[1]), .key_down(keys[2]), .key_right(keys[3]),
        .wallblks(wallblks),
        .left(left), .up(up), .down(down), .right(right),
        .xFlr(xFlr), .xCeil(xCeil), .yFlr(yFlr), .yCeil(yCeil),
        .moved(moved), .blocked(blocked), .won(won)
    );

    player_mover #(.START_X(576), .START_Y(450), .REPEAT_CYCLES(8)) dut_g (
        .clk(clk), .reset(reset),
        .key_left(gkeys[0]), .key_up(gkeys[1]), .key_down(gkeys[2]), .key_right(gkeys[3]),
        .wallblks(1'b0),
        .left(g_left), .up(g_up), .down(g_down), .right(g_right),
        .xFlr(g_xFlr), .xCeil(g_xCeil), .yFlr(g_yFlr), .yCeil(g_yCeil),
        .moved(g_moved), .blocked(g_blocked), .won(g_won)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_x", 32'(xFlr), 32'd0);
        chk("rst_y", 32'(yFlr), 32'd0);
        chk("rst_xceil", 32'(xCeil), 32'd32);
        chk("rst_yceil", 32'(yCeil), 32'd30);
        chk("rst_dirs", 32'({right, down, up, left}), 32'd0);
        chk("rst_pulses", 32'({moved, blocked, won}), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic nav(input logic [3:0] d);
        keys = d;
        tick(6);
        keys = 4'd0;
        tick(4);
    endtask

    initial begin
        do_reset();

        // Up at the top edge is rejected by the edge test.
        keys = 4'b0010;
        tick(5);
        chk("up_edge_blocked", 32'(blocked), 32'd1);
        chk("up_edge_moved", 32'(moved), 32'd0);
        chk("up_edge_y", 32'(yFlr), 32'd0);
        tick(1);
        chk("up_edge_blk_pulse", 32'(blocked), 32'd0);
        keys = 4'd0;
        tick(4);

        // Single right move: 5-edge latency, right request high for exactly 2 cycles.
        keys = 4'b1000;
        tick(2);
        chk("r_dir_e2", 32'(right), 32'd0);
        tick(1);
        chk("r_dir_e3", 32'(right), 32'd1);
        tick(1);
        chk("r_dir_e4", 32'(right), 32'd1);
        chk("r_x_e4", 32'(xFlr), 32'd0);
        tick(1);
        chk("r_dir_e5", 32'(right), 32'd0);
        chk("r_x_e5", 32'(xFlr), 32'd32);
        chk("r_xceil_e5", 32'(xCeil), 32'd64);
        chk("r_y_e5", 32'(yFlr), 32'd0);
        chk("r_moved_e5", 32'(moved), 32'd1);
        tick(1);
        chk("r_moved_e6", 32'(moved), 32'd0);
        keys = 4'd0;
        tick(4);

        // Hold-to-repeat down: moves at edges 5, 15, 25.
        do_reset();
        keys = 4'b0100;
        tick(5);
        chk("rep_y1", 32'(yFlr), 32'd30);
        tick(9);
        chk("rep_y1_hold", 32'(yFlr), 32'd30);
        tick(1);
        chk("rep_y2", 32'(yFlr), 32'd60);
        chk("rep_moved2", 32'(moved), 32'd1);
        tick(9);
        chk("rep_y2_hold", 32'(yFlr), 32'd60);
        tick(1);
        chk("rep_y3", 32'(yFlr), 32'd90);
        keys = 4'd0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            acc += int'(moved);
        end
        chk("rep_release_moves", 32'(acc), 32'd0);
        chk("rep_release_y", 32'(yFlr), 32'd90);

        // Two keys at once: no request, no pulses.
        do_reset();
        keys = 4'b0011;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            acc += int'(left) + int'(up) + int'(down) + int'(right) + int'(moved) + int'(blocked);
        end
        chk("diag_activity", 32'(acc), 32'd0);
        chk("diag_xy", 32'({xFlr, yFlr}), 32'd0);
        keys = 4'd0;
        tick(3);

        // Walk to (480,120), then a left move rejected by the wall checker.
        for (int i = 0; i < 15; i++) nav(4'b1000);
        for (int i = 0; i < 4; i++) nav(4'b0100);
        chk("nav_x", 32'(xFlr), 32'd480);
        chk("nav_y", 32'(yFlr), 32'd120);
        wall_en = 1'b1;
        keys = 4'b0001;
        tick(5);
        chk("wall_blocked", 32'(blocked), 32'd1);
        chk("wall_moved", 32'(moved), 32'd0);
        chk("wall_x", 32'(xFlr), 32'd480);
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            acc += int'(blocked) + int'(moved);
        end
        chk("wall_single_pulse", 32'(acc), 32'd0);
        keys = 4'd0;
        wall_en = 1'b0;
        tick(4);

        // Goal reached on the second instance; later keys do nothing.
        gkeys = 4'b1000;
        tick(5);
        chk("goal_x", 32'(g_xFlr), 32'd608);
        chk("goal_won", 32'(g_won), 32'd1);
        chk("goal_moved", 32'(g_moved), 32'd1);
        gkeys = 4'd0;
        tick(4);
        gkeys = 4'b0001;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            acc += int'(g_left) + int'(g_moved) + int'(g_blocked);
        end
        chk("done_activity", 32'(acc), 32'd0);
        chk("done_x", 32'(g_xFlr), 32'd608);
        chk("done_won", 32'(g_won), 32'd1);
        gkeys = 4'd0;

        // Asynchronous reset while the main instance sits in HOLD.
        keys = 4'b1000;
        tick(6);
        chk("hold_x", 32'(xFlr), 32'd512);
        #2 reset = 1'b1;
        #1;
        chk("areset_x", 32'(xFlr), 32'd0);
        chk("areset_y", 32'(yFlr), 32'd0);
        chk("areset_g_won", 32'(g_won), 32'd0);
        chk("areset_g_x", 32'(g_xFlr), 32'd576);
        keys = 4'd0;
        tick(2);
        reset = 1'b0;
        tick(3);
        chk("post_reset_x", 32'(xFlr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
